// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants, FSM states and data types for the IIR feeder blocks
package iir_pkg;

  localparam int DW = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  typedef logic signed [DW-1:0] sample_t;
  typedef logic signed [DW-1:0] coef_t;

endpackage

// File: rtl/iir_sample_feeder_if.sv
// rtl/iir_sample_feeder_if.sv - source/filter-side signal bundle of the sample feeder
interface iir_sample_feeder_if #(
  parameter int AW = 3
);
  import iir_pkg::*;

  logic         en;
  sample_t      in_data;
  logic         in_valid;
  logic         in_ready;
  coef_t        coef_in;
  logic         coef_ld;
  sample_t      x_out;
  coef_t        a_out;
  logic         strobe;
  logic         underrun;
  logic [AW:0]  level;

  modport slave (
    input  en, in_data, in_valid, coef_in, coef_ld,
    output in_ready, x_out, a_out, strobe, underrun, level
  );

  modport master (
    output en, in_data, in_valid, coef_in, coef_ld,
    input  in_ready, x_out, a_out, strobe, underrun, level
  );

endinterface

// File: rtl/iir_sync_fifo.sv
// rtl/iir_sync_fifo.sv - single-clock FIFO with registered occupancy; push ignored when full,
// pop ignored when empty.
module iir_sync_fifo #(
  parameter int DW    = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  // Full/empty come only from the registered level, so in_ready never sees the pop.
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/iir_sample_feeder.sv
// rtl/iir_sample_feeder.sv - paces FIFO'd samples to the IIR filter one every RATE clocks and
// applies pending coefficients on the same strobe. Optional build macro: IIR_FEED_HOLD_EN.
module iir_sample_feeder
  import iir_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int RATE      = 4,
  parameter int PRIME_LVL = 2
) (
  input  logic                clk,
  input  logic                rst,
  iir_sample_feeder_if.slave  bus
);

  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  sample_t       x_q, x_d;
  coef_t         a_q, a_d;
  coef_t         pend_q, pend_d;
  logic          pflag_q, pflag_d;
  logic          strobe_q, strobe_d;
  logic          und_q, und_d;
  logic          tick;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_level;
  logic [DW-1:0] fifo_rdata;

  iir_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .wdata (bus.in_data),
    .pop   (tick),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.en) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        cnt_d = '0;
        if (!bus.en)                                 state_d = ST_IDLE;
        else if (fifo_level >= (AW+1)'(PRIME_LVL))   state_d = ST_RUN;
      end
      ST_RUN: begin
        // Dropping en abandons the current period: no tick in the exit cycle.
        if (!bus.en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(RATE - 1)) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    x_d      = x_q;
    a_d      = a_q;
    pend_d   = pend_q;
    pflag_d  = pflag_q;
    strobe_d = 1'b0;
    und_d    = und_q;
    if (tick) begin
      strobe_d = 1'b1;
      if (!fifo_empty) begin
        x_d = sample_t'(fifo_rdata);
      end else begin
        und_d = 1'b1;
`ifdef IIR_FEED_HOLD_EN
        x_d = x_q;
`else
        x_d = '0;
`endif
      end
      if (pflag_q) a_d = pend_q;
      pflag_d = 1'b0;
    end
    // A load coinciding with a tick lands in pending and waits for the next tick.
    if (bus.coef_ld) begin
      pend_d  = bus.coef_in;
      pflag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      a_q      <= '0;
      pend_q   <= '0;
      pflag_q  <= 1'b0;
      strobe_q <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      a_q      <= a_d;
      pend_q   <= pend_d;
      pflag_q  <= pflag_d;
      strobe_q <= strobe_d;
      und_q    <= und_d;
    end
  end

  assign bus.in_ready = !fifo_full;
  assign bus.x_out    = x_q;
  assign bus.a_out    = a_q;
  assign bus.strobe   = strobe_q;
  assign bus.underrun = und_q;
  assign bus.level    = fifo_level;

endmodule
